// File: rtl/bdi_compressor_unit.sv
// Serial Base-Delta-Immediate compressor: one candidate encoding is tried per cycle
// in increasing-size order, and the first enabled one that fits is emitted.
module bdi_compressor_unit #(
  parameter logic [8:0] EN_MASK = 9'h1FF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_line,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [259:0] out_data,
  output logic [8:0]   out_size
);

  typedef enum logic [1:0] {IDLE, SCAN, OUT} state_t;

  state_t         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [255:0]   line_q, line_d;
  logic [259:0]   out_data_q, out_data_d;
  logic [8:0]     out_size_q, out_size_d;
  logic [260:0]   try_c;
  logic           en_c;
  logic [7:0]     en_low;

  // Returns {fit, encoded word}; word j's delta sits at P[bw + dw*j], flag of word j at bit 3+j.
  function automatic logic [260:0] bd_try(input logic [255:0] line, input int bw,
                                          input int dw, input logic [3:0] con);
    logic [63:0]  bmask;
    logic [63:0]  dmask;
    logic [63:0]  base;
    logic [63:0]  w;
    logic [63:0]  mag;
    logic [259:0] enc;
    logic         fit;
    int           nw;
    bmask = (bw == 64) ? '1 : ((64'd1 << bw) - 64'd1);
    dmask = (64'd1 << dw) - 64'd1;
    nw    = 256 / bw;
    base  = line[63:0] & bmask;
    w     = '0;
    mag   = '0;
    fit   = 1'b1;
    enc   = '0;
    enc[3:0] = con;
    enc   = enc | (260'(base) << (3 + nw));
    for (int j = 1; j < 16; j++) begin
      if (j < nw) begin
        w = 64'(line >> (j * bw)) & bmask;
        if (w >= base) begin
          enc[3+j] = 1'b1;
          mag      = w - base;
        end else begin
          mag      = base - w;
        end
        if ((mag & ~dmask) != 64'd0) fit = 1'b0;
        enc = enc | (260'(mag & dmask) << (3 + nw + bw + dw * j));
      end
    end
    return {fit, enc};
  endfunction

  function automatic logic [8:0] slot_size(input logic [3:0] idx);
    case (idx)
      4'd0:    return 9'd4;
      4'd1:    return 9'd68;
      4'd2:    return 9'd103;
      4'd3:    return 9'd107;
      4'd4:    return 9'd135;
      4'd5:    return 9'd163;
      4'd6:    return 9'd171;
      4'd7:    return 9'd199;
      default: return 9'd260;
    endcase
  endfunction

  assign en_low = EN_MASK[7:0];
  // Slot 8 (raw) is unconditionally enabled so the scan always terminates.
  assign en_c   = idx_q[3] | en_low[idx_q[2:0]];

  always_comb begin
    try_c = '0;
    case (idx_q)
      4'd0:    try_c = {(line_q == 256'd0), 260'd0};
      4'd1:    try_c = {(line_q[63:0] == line_q[127:64]) && (line_q[63:0] == line_q[191:128]) &&
                        (line_q[63:0] == line_q[255:192]), 192'd0, line_q[63:0], 4'd7};
      4'd2:    try_c = bd_try(line_q, 64, 8, 4'd1);
      4'd3:    try_c = bd_try(line_q, 32, 8, 4'd4);
      4'd4:    try_c = bd_try(line_q, 64, 16, 4'd2);
      4'd5:    try_c = bd_try(line_q, 16, 8, 4'd6);
      4'd6:    try_c = bd_try(line_q, 32, 16, 4'd5);
      4'd7:    try_c = bd_try(line_q, 64, 32, 4'd3);
      default: try_c = {1'b1, line_q, 4'd8};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    line_d     = line_q;
    out_data_d = out_data_q;
    out_size_d = out_size_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          line_d  = in_line;
          idx_d   = 4'd0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (try_c[260] && en_c) begin
          out_data_d = try_c[259:0];
          out_size_d = slot_size(idx_q);
          state_d    = OUT;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= 4'd0;
      out_data_q <= '0;
      out_size_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      out_data_q <= out_data_d;
      out_size_q <= out_size_d;
    end
  end

  // The captured line is pure data; control state decides whether it is meaningful.
  always_ff @(posedge clk) begin
    line_q <= line_d;
  end

  assign out_data = out_data_q;
  assign out_size = out_size_q;

endmodule

// File: tb/tb_bdi_compressor_unit.sv
// Directed bench for bdi_compressor_unit: each encoding class, latency, backpressure,
// asynchronous reset during a scan, and a disabled priority slot.
module tb_bdi_compressor_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_valid2;
  logic         out_ready;
  logic [255:0] in_line;
  logic         in_ready, out_valid, in_ready2, out_valid2;
  logic [259:0] out_data, out_data2;
  logic [8:0]   out_size, out_size2;

  int tests = 0;
  int fails = 0;

  localparam logic [63:0] REPW = 64'hDEADBEEF_01234567;

  always #5 clk = ~clk;

  bdi_compressor_unit u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_line(in_line),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_size(out_size)
  );

  bdi_compressor_unit #(.EN_MASK(9'h1FD)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .in_line(in_line),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_size(out_size2)
  );

  task automatic accept(input logic [255:0] line);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    in_line  = line;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctrl: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    end
    tests++;
    if (out_data !== 260'd0 || out_size !== 9'd0) begin
      fails++;
      $display("FAIL reset_data: data=%h size=%0d required 0/0", out_data, out_size);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero();
    int lat;
    accept(256'd0);
    wait_out(lat);
    tests++;
    if (lat !== 1) begin fails++; $display("FAIL zero_latency: got %0d required 1", lat); end
    tests++;
    if (out_data !== 260'd0 || out_size !== 9'd4) begin
      fails++;
      $display("FAIL zero_enc: data=%h size=%0d required 0/4", out_data, out_size);
    end
    release_out();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL zero_return: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_repeated();
    int lat;
    logic [259:0] exp;
    exp = '0;
    exp[3:0] = 4'd7;
    exp[67:4] = REPW;
    accept({4{REPW}});
    wait_out(lat);
    tests++;
    if (lat !== 2) begin fails++; $display("FAIL rep_latency: got %0d required 2", lat); end
    tests++;
    if (out_data !== exp || out_size !== 9'd68) begin
      fails++;
      $display("FAIL rep_enc: data=%h size=%0d required %h/68", out_data, out_size, exp);
    end
    release_out();
  endtask

  task automatic test_b8d1();
    int lat;
    logic [259:0] exp;
    exp = '0;
    exp[3:0]   = 4'd1;
    exp[6:4]   = 3'b101;
    exp[70:7]  = 64'd1000;
    exp[86:79] = 8'd5;
    exp[94:87] = 8'd8;
    accept({64'd1000, 64'd992, 64'd1005, 64'd1000});
    wait_out(lat);
    tests++;
    if (lat !== 3) begin fails++; $display("FAIL b8d1_latency: got %0d required 3", lat); end
    tests++;
    if (out_data !== exp || out_size !== 9'd103) begin
      fails++;
      $display("FAIL b8d1_enc: data=%h size=%0d required %h/103", out_data, out_size, exp);
    end
    release_out();
  endtask

  task automatic test_b2d1();
    int lat;
    logic [255:0] l;
    logic [259:0] exp;
    for (int i = 0; i < 16; i++) l[16*i +: 16] = 16'h1000;
    l[31:16] = 16'h10FF;
    l[47:32] = 16'h0F01;
    l[63:48] = 16'h1005;
    exp = '0;
    exp[3:0]   = 4'd6;
    exp[18:4]  = 15'h7FFD;
    exp[34:19] = 16'h1000;
    exp[50:43] = 8'hFF;
    exp[58:51] = 8'hFF;
    exp[66:59] = 8'h05;
    accept(l);
    wait_out(lat);
    tests++;
    if (lat !== 6) begin fails++; $display("FAIL b2d1_latency: got %0d required 6", lat); end
    tests++;
    if (out_data !== exp || out_size !== 9'd163) begin
      fails++;
      $display("FAIL b2d1_enc: data=%h size=%0d required %h/163", out_data, out_size, exp);
    end
    release_out();
  endtask

  task automatic test_raw();
    int lat;
    logic [255:0] l;
    for (int i = 0; i < 16; i++) l[16*i +: 16] = 16'h1000;
    l[31:16] = 16'h1200;
    l[47:32] = 16'h0F01;
    l[63:48] = 16'h1005;
    accept(l);
    wait_out(lat);
    tests++;
    if (lat !== 9) begin fails++; $display("FAIL raw_latency: got %0d required 9", lat); end
    tests++;
    if (out_data !== {l, 4'd8} || out_size !== 9'd260) begin
      fails++;
      $display("FAIL raw_enc: data=%h size=%0d required %h/260", out_data, out_size, {l, 4'd8});
    end
    release_out();
  endtask

  task automatic test_backpressure();
    int lat;
    int highs;
    logic [259:0] exp;
    exp = '0;
    exp[3:0] = 4'd7;
    exp[67:4] = REPW;
    accept({4{REPW}});
    wait_out(lat);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_line  = 256'd0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp || out_size !== 9'd68) begin
        fails++;
        $display("FAIL bp_hold[%0d]: valid=%0b in_ready=%0b data=%h size=%0d required 1/0/%h/68",
                 c, out_valid, in_ready, out_data, out_size, exp);
      end
    end
    in_valid = 1'b0;
    release_out();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL bp_return: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    end
    highs = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) highs++;
    end
    tests++;
    if (highs !== 0) begin fails++; $display("FAIL bp_ignored_input: out_valid cycles=%0d required 0", highs); end
  endtask

  task automatic test_en_mask();
    int lat;
    logic [259:0] exp;
    exp = '0;
    exp[3:0]  = 4'd1;
    exp[6:4]  = 3'b111;
    exp[70:7] = REPW;
    @(negedge clk);
    in_line   = {4{REPW}};
    in_valid2 = 1'b1;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    tests++;
    if (lat !== 3) begin fails++; $display("FAIL mask_latency: got %0d required 3", lat); end
    tests++;
    if (out_data2 !== exp || out_size2 !== 9'd103) begin
      fails++;
      $display("FAIL mask_enc: data=%h size=%0d required %h/103", out_data2, out_size2, exp);
    end
    release_out();
  endtask

  task automatic test_reset_mid_scan();
    int highs;
    logic [255:0] l;
    for (int i = 0; i < 16; i++) l[16*i +: 16] = 16'h1000;
    l[31:16] = 16'h1200;
    l[63:48] = 16'h1005;
    accept(l);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL midscan_ctrl: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    end
    tests++;
    if (out_data !== 260'd0 || out_size !== 9'd0) begin
      fails++;
      $display("FAIL midscan_data: data=%h size=%0d required 0/0", out_data, out_size);
    end
    @(negedge clk);
    rst_n = 1'b1;
    highs = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) highs++;
    end
    tests++;
    if (highs !== 0) begin fails++; $display("FAIL midscan_no_output: out_valid cycles=%0d required 0", highs); end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    out_ready = 1'b0;
    in_line   = '0;
    test_reset();
    test_zero();
    test_repeated();
    test_b8d1();
    test_b2d1();
    test_raw();
    test_backpressure();
    test_en_mask();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bdi_compressor_unit.md
# bdi_compressor_unit

Multi-cycle Base-Delta-Immediate compressor for 256-bit cache lines. It produces the 260-bit encoded word consumed by `DecompressorUnit`: CoN in bits [3:0], then flags, then payload. It sits between the cache fill path and the compressed-line store. Encodings are tried serially in increasing-size order, and the first one that fits is emitted.

## Interface
- `EN_MASK`, default 9'h1FF: per-candidate enable, bit k = priority slot k. Slot 8 (raw) is always treated as enabled.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `in_line` is valid.
- `in_ready` out 1: high only in IDLE; a line is accepted when `in_valid` && `in_ready`.
- `in_line` in 256: uncompressed line; word 0 sits at the LSBs.
- `out_valid` out 1: encoded word is available.
- `out_ready` in 1: consumer accepts the encoded word.
- `out_data` out 260: encoded word.
- `out_size` out 9: significant encoded length in bits.

## Operation
- States:
  - IDLE: `in_ready`=1. On handshake, register `in_line`, set idx=0, go to SCAN.
  - SCAN: evaluate candidate idx. On a fit (and enabled), register `out_data`/`out_size` and go to OUT. Otherwise idx++.
  - OUT: `out_valid`=1. Hold `out_data`/`out_size` stable until `out_ready`, then go to IDLE.
- Priority slots, as idx / CoN / size:
  - 0 / 0 / 4: zero
  - 1 / 7 / 68: repeated
  - 2 / 1 / 103: B8D1
  - 3 / 4 / 107: B4D1
  - 4 / 2 / 135: B8D2
  - 5 / 6 / 163: B2D1
  - 6 / 5 / 171: B4D2
  - 7 / 3 / 199: B8D4
  - 8 / 8 / 260: raw
- Delta rule for word w against base b:
  - If w ≥ b (unsigned): flag=1, mag=w−b.
  - Else: flag=0, mag=b−w.
  - The candidate fits only if mag < 2^(8·D) for every non-base word.
  - Base = word 0 of the base width.
- Field layout. P = payload slice, unused bits = 0, flag bit k belongs to word k+1.
  - CoN 0: all bits zero except CoN.
  - CoN 7: P=[259:4]. P[63:0]=word0. Fits iff all four 64-bit words are equal.
  - CoN 1/2/3:
    - flags=[6:4], P=[259:7], P[63:0]=base.
    - delta k at P[72+8k +: 8] (CoN 1), P[80+16k +: 16] (CoN 2), P[96+32k +: 32] (CoN 3), k=0..2.
  - CoN 4/5:
    - flags=[10:4], P=[259:11], P[31:0]=base.
    - delta k at P[40+8k +: 8] (CoN 4) or P[48+16k +: 16] (CoN 5), k=0..6.
  - CoN 6:
    - flags=[18:4], P=[259:19], P[15:0]=base.
    - delta k at P[24+8k +: 8], k=0..14.
  - CoN 8: [259:4]=`in_line`.
- An equal word encodes as flag=1, mag=0.
- The scan never runs past idx 8: raw always fits.

## Timing
- Reset (async, any state): state=IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `out_size`=0, idx=0. An in-flight line is discarded.
- Acceptance at edge E0. The winning slot k is registered at edge E(k+1), and `out_valid` is high from that edge.
  - Zero line: latency 1.
  - Raw line: latency 9.
- One SCAN cycle is spent per slot, including disabled slots.
- `out_valid` stays high with stable data while `out_ready`=0.
- The output handshake at edge Ex returns to IDLE: `out_valid`=0 and `in_ready`=1 after Ex. The next acceptance is at Ex+1 at the earliest.
- `in_valid` during SCAN/OUT is ignored, since `in_ready`=0. No back-to-back overlap.
- Throughput: at most one line every k+3 cycles.

## Test plan
- Zero line:
  - Stimulus: `in_line`=0, `out_ready`=1.
  - Required: `out_valid` 1 cycle after accept, `out_data`=260'h0, `out_size`=4, then `in_ready` high the next cycle.
- Repeated line:
  - Stimulus: all four 64-bit words = 64'hDEADBEEF_01234567.
  - Required: CoN=7, `out_data`[67:4] = that value, upper bits zero, `out_size`=68, latency 2.
- B8D1 with mixed sign:
  - Stimulus: words = 1000, 1005, 0x3E0 (992), 1000 (decimal).
  - Required: CoN=1, flags=3'b101, deltas 5, 8, 0, `out_size`=103.
  - Feeding `out_data` into `DecompressorUnit` must reproduce the line.
- B2D1 vs fallback:
  - Line of 16-bit words, base 0x1000, others 0x1000 ± ≤255, but 64/32-bit deltas too large: CoN=6, latency 6.
  - One word changed to 0x1200: raw, CoN=8, latency 9.
- Backpressure and reset:
  - Hold `out_ready`=0 for 5 cycles: `out_data` stable, `in_ready`=0 throughout.
  - Assert `rst_n`=0 mid-SCAN: `out_valid` and `in_ready` take reset values immediately, with no output emitted.
- `EN_MASK`=9'h1FD (slot 1 disabled):
  - Repeated-value line encodes as B8D1 with zero deltas (CoN=1, flags=3'b111), latency 3.
